bankgroup_scheduler: RTL
========================

Name: bankgroup_scheduler

Overview:
- Command scheduler in front of one DDR bank group.
- Accepts single read/write requests (bank, row, column) on a valid/ready handshake and tracks the open row of every bank.
- Sequences PRE/ACT/RD/WR onto the group's 19-bit one-hot command bus, honouring tRCD, tRP, tRAS and tCCD.
- Open-page policy, one request in flight, in-order service.

Parameters:
- ADDRWIDTH, 17, row address width
- BANKSPERGROUP, 2, banks in the group
- COLS, 1024, columns per row
- TRCD, 3, ACT to RD/WR, cycles (min 1)
- TRP, 3, PRE to ACT same bank, cycles (min 1)
- TRAS, 8, ACT to PRE same bank, cycles (min 1)
- TCCD, 4, CAS to CAS anywhere in group, cycles (min 1)
- ACT_BIT / PRE_BIT / RD_BIT / WR_BIT, 0 / 1 / 2 / 3, bit index in commands
- derived: BAWIDTH = $clog2(BANKSPERGROUP), CADDRWIDTH = $clog2(COLS)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- halt  in  1  emulation freeze
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1=write, 0=read
- req_bank  in  BAWIDTH+1  target bank
- req_row  in  ADDRWIDTH  target row
- req_col  in  CADDRWIDTH  target column
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: bank out of range
- commands  out  19  one-hot command to bank group
- ba  out  BAWIDTH+1  bank address for commands
- row  out  ADDRWIDTH  row for ACT
- column  out  CADDRWIDTH  column for RD/WR

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE; all banks closed; all timing counters 0.
  - commands=0, ba=0, row=0, column=0.
  - req_ready=0 while in reset; resp_valid=0, resp_err=0.
  - Reset mid-sequence aborts the sequence with no response.
- FSM states: IDLE, WAIT_PRE, WAIT_ACT, WAIT_CAS, DONE.
- IDLE:
  - req_ready=1 iff !halt.
  - On accept (cycle A), latch we/bank/row/col and decode:
    - bank>=BANKSPERGROUP → DONE with err.
    - bank open, same row (hit) → WAIT_CAS.
    - bank open, different row (miss) → WAIT_PRE.
    - bank closed → WAIT_ACT.
- Commands are issued at earliest A+1.
- Issue conditions:
  - PRE: ≥TRAS cycles since that bank's ACT. After PRE, bank marked closed.
  - ACT: ≥TRP cycles since that bank's PRE (reset counts as satisfied). After ACT, bank open with latched row.
  - RD/WR: ≥TRCD since that bank's ACT and ≥TCCD since the last CAS to any bank. After CAS → DONE.
- Command bus:
  - Exactly one bit of commands set in an issue cycle; commands=0 in all other cycles.
  - ba, row, column are valid in issue cycles only; hold last value otherwise.
- DONE: resp_valid=1 (resp_err per decode) for one cycle → IDLE.
  - Next accept is possible at DONE+1.
- Counters:
  - Per-bank tRCD/tRP/tRAS down-counters, plus one group tCCD counter.
  - Load on the related command; decrement each non-halted cycle; saturate at 0.
  - Width = $clog2(max timing+1).
- halt=1:
  - FSM, counters and latched request frozen.
  - commands=0, req_ready=0.
  - A pending resp_valid is deferred to the first non-halted cycle.
- Simultaneous events:
  - A request arriving while not IDLE waits (req_ready=0; no queue).
  - halt together with req_valid in IDLE → no accept.
- Open rows persist indefinitely. The block never issues REF and never auto-precharges.

Test Plan:
- Cold read: reset, accept rd bank0 row5 col16 at cycle 6 → ACT (ba=0,row=5) at 7, RD (column=16) at 10, resp_valid at 11, commands=0 elsewhere.
- Row hit + tCCD: after the first RD at C, accept rd bank0 row5 col32 at C+2 → RD at C+4 (not C+3), no ACT.
- Row miss + tRAS: ACT row5 at 1, RD at 4, accept wr bank0 row9 at 6 → PRE at 9 (tRAS-bound), ACT row9 at 12, WR at 15, resp_valid at 16.
- Bank interleave: bank0 row5 open (ACT at 1, RD at 4), accept rd bank1 row7 at 6 → ACT ba=1 at 7, RD ba=1 at 10; bank0 stays open (subsequent bank0 row5 read is a hit).
- halt for 5 cycles while in WAIT_CAS → commands stay 0, RD delayed exactly 5 cycles, req_ready=0 throughout.
- Error and reset: req_bank=2 (BANKSPERGROUP=2) → no command, resp_valid=1 with resp_err=1 one cycle after accept. Separately, rst=0 between ACT and RD → commands=0 immediately, no resp. After release, a read to the same row issues ACT again (bank closed).

Source files
------------

// File: rtl/bankgroup_scheduler.sv
// Single-request PRE/ACT/RD/WR sequencer for one DDR bank group, open-page policy.
// Tracks open rows per bank and enforces tRCD/tRP/tRAS per bank plus tCCD group-wide.
module bankgroup_scheduler #(
   parameter int ADDRWIDTH     = 17,
   parameter int BANKSPERGROUP = 2,
   parameter int COLS          = 1024,
   parameter int TRCD          = 3,
   parameter int TRP           = 3,
   parameter int TRAS          = 8,
   parameter int TCCD          = 4,
   parameter int ACT_BIT       = 0,
   parameter int PRE_BIT       = 1,
   parameter int RD_BIT        = 2,
   parameter int WR_BIT        = 3,
   localparam int BAWIDTH      = $clog2(BANKSPERGROUP),
   localparam int CADDRWIDTH   = $clog2(COLS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  halt,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [BAWIDTH:0]      req_bank,
   input  logic [ADDRWIDTH-1:0]  req_row,
   input  logic [CADDRWIDTH-1:0] req_col,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [18:0]           commands,
   output logic [BAWIDTH:0]      ba,
   output logic [ADDRWIDTH-1:0]  row,
   output logic [CADDRWIDTH-1:0] column
);

   localparam int BIDXW  = (BAWIDTH > 0) ? BAWIDTH : 1;
   localparam int MAXT_A = (TRCD > TRP) ? TRCD : TRP;
   localparam int MAXT_B = (TRAS > TCCD) ? TRAS : TCCD;
   localparam int MAXT   = (MAXT_A > MAXT_B) ? MAXT_A : MAXT_B;
   localparam int CNTW   = $clog2(MAXT + 1);

   // A counter loaded with T-1 reaches zero exactly T cycles after the command.
   localparam logic [CNTW-1:0] TRCD_L = CNTW'(TRCD - 1);
   localparam logic [CNTW-1:0] TRP_L  = CNTW'(TRP - 1);
   localparam logic [CNTW-1:0] TRAS_L = CNTW'(TRAS - 1);
   localparam logic [CNTW-1:0] TCCD_L = CNTW'(TCCD - 1);
   localparam logic [BAWIDTH:0] NBANKS = (BAWIDTH + 1)'(BANKSPERGROUP);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WAIT_PRE = 3'd1;
   localparam logic [2:0] WAIT_ACT = 3'd2;
   localparam logic [2:0] WAIT_CAS = 3'd3;
   localparam logic [2:0] DONE     = 3'd4;

   logic [2:0]            state_q, state_d;
   logic                  rwe_q, rwe_d;
   logic                  rerr_q, rerr_d;
   logic [BAWIDTH:0]      rbank_q, rbank_d;
   logic [ADDRWIDTH-1:0]  rrow_q, rrow_d;
   logic [CADDRWIDTH-1:0] rcol_q, rcol_d;

   logic [BANKSPERGROUP-1:0] open_q, open_d;
   logic [ADDRWIDTH-1:0]     orow_q [BANKSPERGROUP];
   logic [ADDRWIDTH-1:0]     orow_d [BANKSPERGROUP];
   logic [CNTW-1:0]          trcd_q [BANKSPERGROUP];
   logic [CNTW-1:0]          trcd_d [BANKSPERGROUP];
   logic [CNTW-1:0]          trp_q  [BANKSPERGROUP];
   logic [CNTW-1:0]          trp_d  [BANKSPERGROUP];
   logic [CNTW-1:0]          tras_q [BANKSPERGROUP];
   logic [CNTW-1:0]          tras_d [BANKSPERGROUP];
   logic [CNTW-1:0]          tccd_q, tccd_d;

   logic [BAWIDTH:0]      ba_q, ba_d;
   logic [ADDRWIDTH-1:0]  arow_q, arow_d;
   logic [CADDRWIDTH-1:0] col_q, col_d;
   logic [18:0]           cmd;
   logic [BIDXW-1:0]      bidx, ridx;

   function automatic logic [CNTW-1:0] sat_dec(input logic [CNTW-1:0] c);
      return (c == '0) ? c : c - CNTW'(1);
   endfunction

   assign bidx = rbank_q[BIDXW-1:0];
   assign ridx = req_bank[BIDXW-1:0];

   always_comb begin
      state_d = state_q;
      rwe_d   = rwe_q;
      rerr_d  = rerr_q;
      rbank_d = rbank_q;
      rrow_d  = rrow_q;
      rcol_d  = rcol_q;
      open_d  = open_q;
      tccd_d  = halt ? tccd_q : sat_dec(tccd_q);
      for (int b = 0; b < BANKSPERGROUP; b++) begin
         orow_d[b] = orow_q[b];
         trcd_d[b] = halt ? trcd_q[b] : sat_dec(trcd_q[b]);
         trp_d[b]  = halt ? trp_q[b]  : sat_dec(trp_q[b]);
         tras_d[b] = halt ? tras_q[b] : sat_dec(tras_q[b]);
      end
      cmd    = '0;
      ba_d   = ba_q;
      arow_d = arow_q;
      col_d  = col_q;

      if (!halt) begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  rwe_d   = req_we;
                  rbank_d = req_bank;
                  rrow_d  = req_row;
                  rcol_d  = req_col;
                  rerr_d  = 1'b0;
                  if (req_bank >= NBANKS) begin
                     rerr_d  = 1'b1;
                     state_d = DONE;
                  end else if (open_q[ridx] && orow_q[ridx] == req_row) begin
                     state_d = WAIT_CAS;
                  end else if (open_q[ridx]) begin
                     state_d = WAIT_PRE;
                  end else begin
                     state_d = WAIT_ACT;
                  end
               end
            end
            WAIT_PRE: begin
               if (tras_q[bidx] == '0) begin
                  cmd[PRE_BIT] = 1'b1;
                  ba_d         = rbank_q;
                  open_d[bidx] = 1'b0;
                  trp_d[bidx]  = TRP_L;
                  state_d      = WAIT_ACT;
               end
            end
            WAIT_ACT: begin
               if (trp_q[bidx] == '0) begin
                  cmd[ACT_BIT] = 1'b1;
                  ba_d         = rbank_q;
                  arow_d       = rrow_q;
                  open_d[bidx] = 1'b1;
                  orow_d[bidx] = rrow_q;
                  trcd_d[bidx] = TRCD_L;
                  tras_d[bidx] = TRAS_L;
                  state_d      = WAIT_CAS;
               end
            end
            WAIT_CAS: begin
               if (trcd_q[bidx] == '0 && tccd_q == '0) begin
                  if (rwe_q) cmd[WR_BIT] = 1'b1;
                  else       cmd[RD_BIT] = 1'b1;
                  ba_d    = rbank_q;
                  col_d   = rcol_q;
                  tccd_d  = TCCD_L;
                  state_d = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rwe_q   <= 1'b0;
         rerr_q  <= 1'b0;
         rbank_q <= '0;
         rrow_q  <= '0;
         rcol_q  <= '0;
         open_q  <= '0;
         tccd_q  <= '0;
         ba_q    <= '0;
         arow_q  <= '0;
         col_q   <= '0;
         for (int b = 0; b < BANKSPERGROUP; b++) begin
            orow_q[b] <= '0;
            trcd_q[b] <= '0;
            trp_q[b]  <= '0;
            tras_q[b] <= '0;
         end
      end else begin
         state_q <= state_d;
         rwe_q   <= rwe_d;
         rerr_q  <= rerr_d;
         rbank_q <= rbank_d;
         rrow_q  <= rrow_d;
         rcol_q  <= rcol_d;
         open_q  <= open_d;
         tccd_q  <= tccd_d;
         ba_q    <= ba_d;
         arow_q  <= arow_d;
         col_q   <= col_d;
         for (int b = 0; b < BANKSPERGROUP; b++) begin
            orow_q[b] <= orow_d[b];
            trcd_q[b] <= trcd_d[b];
            trp_q[b]  <= trp_d[b];
            tras_q[b] <= tras_d[b];
         end
      end
   end

   // Bus fields follow the command combinationally in its issue cycle, then hold.
   assign commands   = cmd;
   assign ba         = ba_d;
   assign row        = arow_d;
   assign column     = col_d;
   assign req_ready  = rst && !halt && (state_q == IDLE);
   assign resp_valid = !halt && (state_q == DONE);
   assign resp_err   = resp_valid && rerr_q;

endmodule
